// File: rtl/dram_ref_reader_pkg.sv
// Shared types and constants for the DRAM reference reader.
package dram_ref_reader_pkg;

   localparam int ADDR_W = 25;
   localparam int LEN_W  = 25;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/dram_ref_reader_if.sv
// Request, DRAM read and reference-block signals of one reader instance.
// master is the reader's view, slave is the engine/DRAM-controller view.
interface dram_ref_reader_if
   import dram_ref_reader_pkg::*;
#(
   parameter int REF_LENGTH = 256,
   parameter int DRAM_WIDTH = 256
);

   logic [ADDR_W-1:0]       ref_addr_in;
   logic [LEN_W-1:0]        ref_length_in;
   logic                    ref_info_valid;
   logic                    busy_out;
   logic [ADDR_W-1:0]       dram_rd_addr_out;
   logic                    dram_rd_req_out;
   logic                    dram_rd_ack;
   logic [DRAM_WIDTH-1:0]   dram_rd_data;
   logic                    dram_rd_data_valid;
   logic [2*REF_LENGTH-1:0] ref_seq_block_out;
   logic                    ref_seq_block_valid_out;
   logic                    ref_seq_block_rdy;

   modport master (
      input  ref_addr_in, ref_length_in, ref_info_valid,
      input  dram_rd_ack, dram_rd_data, dram_rd_data_valid,
      input  ref_seq_block_rdy,
      output busy_out, dram_rd_addr_out, dram_rd_req_out,
      output ref_seq_block_out, ref_seq_block_valid_out
   );

   modport slave (
      output ref_addr_in, ref_length_in, ref_info_valid,
      output dram_rd_ack, dram_rd_data, dram_rd_data_valid,
      output ref_seq_block_rdy,
      input  busy_out, dram_rd_addr_out, dram_rd_req_out,
      input  ref_seq_block_out, ref_seq_block_valid_out
   );

endinterface

// File: rtl/dram_ref_reader_ref_block_fifo.sv
// First-word-fall-through block FIFO; count feeds the reader's credit check.
module ref_block_fifo #(
   parameter int  WIDTH = 512,
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             valid_q;

   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         // NOTE: storage is cleared too, because the head entry drives a
         // module output that must read as zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // NOTE: every state update here is non-blocking so all registers
         // see pre-edge values; blocking would create order-dependent races.
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_d;
         valid_q <= (count_d != '0);
      end
   end

   assign out_data  = mem[rd_ptr];
   assign out_valid = valid_q;
   assign count     = count_q;

endmodule

// File: rtl/dram_ref_reader.sv
// Fetches reference blocks from DRAM and streams them to a Smith-Waterman engine.
// Optional DRAM_REF_READER_STATS_EN adds stall/wait cycle counters.
module dram_ref_reader
   import dram_ref_reader_pkg::*;
#(
   parameter int REF_LENGTH = 256,
   parameter int DRAM_WIDTH = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   dram_ref_reader_if.master   bus
`ifdef DRAM_REF_READER_STATS_EN
   ,
   output logic [31:0]         stall_cycles_out,
   output logic [31:0]         dram_wait_cycles_out
`endif
);

   localparam int BLK_W  = 2 * REF_LENGTH;
   localparam int BEATS  = BLK_W / DRAM_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W  = CNT_W + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  blocks_req_q, blocks_req_d;
   logic [LEN_W-1:0]  delivered_q, delivered_d;
   logic [BEAT_W-1:0] req_beat_q, req_beat_d;
   logic [BEAT_W-1:0] rx_beat_q, rx_beat_d;
   logic [CNT_W-1:0]  in_flight_q, in_flight_d;
   logic [BLK_W-1:0]  pack_q, pack_d;

   logic              push;
   logic [BLK_W-1:0]  push_data;
   logic              pop;
   logic              start_blk;
   logic              credit;
   logic [BLK_W-1:0]  fifo_data;
   logic              fifo_valid;
   logic [CNT_W-1:0]  fifo_count;

   ref_block_fifo #(
      .WIDTH (BLK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .out_data  (fifo_data),
      .out_valid (fifo_valid),
      .count     (fifo_count)
   );

   // A new block may start only if every block already in flight still has
   // a FIFO slot reserved, so returning beats never need to be dropped.
   assign credit = (SUM_W'(fifo_count) + SUM_W'(in_flight_q)) < SUM_W'(FIFO_DEPTH);
   assign pop    = fifo_valid && bus.ref_seq_block_rdy;

   always_comb begin
      // NOTE: every variable gets its default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      req_d        = req_q;
      addr_d       = addr_q;
      next_addr_d  = next_addr_q;
      len_d        = len_q;
      blocks_req_d = blocks_req_q;
      delivered_d  = delivered_q;
      req_beat_d   = req_beat_q;
      rx_beat_d    = rx_beat_q;
      pack_d       = pack_q;
      push         = 1'b0;
      push_data    = pack_q;
      start_blk    = 1'b0;

      if (pop) delivered_d = delivered_q + 1'b1;

      // Return path: beats arrive in request order and cannot be stalled.
      if (bus.dram_rd_data_valid) begin
         for (int i = 0; i < BEATS; i++) begin
            if (rx_beat_q == BEAT_W'(i)) push_data[i*DRAM_WIDTH +: DRAM_WIDTH] = bus.dram_rd_data;
         end
         pack_d = push_data;
         if (rx_beat_q == LAST_BEAT) begin
            push      = 1'b1;
            rx_beat_d = '0;
         end else begin
            rx_beat_d = rx_beat_q + 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (bus.ref_info_valid && (bus.ref_length_in != '0)) begin
               state_d      = FETCH;
               len_d        = bus.ref_length_in;
               blocks_req_d = '0;
               delivered_d  = '0;
               req_beat_d   = '0;
               req_d        = 1'b1;
               addr_d       = bus.ref_addr_in;
               next_addr_d  = bus.ref_addr_in + 1'b1;
               start_blk    = 1'b1;
            end
         end
         FETCH: begin
            if (req_q) begin
               if (bus.dram_rd_ack) begin
                  if (req_beat_q != LAST_BEAT) begin
                     req_beat_d  = req_beat_q + 1'b1;
                     addr_d      = next_addr_q;
                     next_addr_d = next_addr_q + 1'b1;
                  end else begin
                     req_beat_d   = '0;
                     blocks_req_d = blocks_req_q + 1'b1;
                     if (blocks_req_q + 1'b1 == len_q) begin
                        req_d   = 1'b0;
                        state_d = DRAIN;
                     end else if (credit) begin
                        start_blk   = 1'b1;
                        addr_d      = next_addr_q;
                        next_addr_d = next_addr_q + 1'b1;
                     end else begin
                        req_d = 1'b0;
                     end
                  end
               end
            end else if (credit) begin
               start_blk   = 1'b1;
               req_d       = 1'b1;
               addr_d      = next_addr_q;
               next_addr_d = next_addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (pop && (delivered_q + 1'b1 == len_q)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d != IDLE);
      in_flight_d = in_flight_q + CNT_W'(start_blk) - CNT_W'(push);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         req_q        <= 1'b0;
         addr_q       <= '0;
         next_addr_q  <= '0;
         len_q        <= '0;
         blocks_req_q <= '0;
         delivered_q  <= '0;
         req_beat_q   <= '0;
         rx_beat_q    <= '0;
         in_flight_q  <= '0;
         pack_q       <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         next_addr_q  <= next_addr_d;
         len_q        <= len_d;
         blocks_req_q <= blocks_req_d;
         delivered_q  <= delivered_d;
         req_beat_q   <= req_beat_d;
         rx_beat_q    <= rx_beat_d;
         in_flight_q  <= in_flight_d;
         pack_q       <= pack_d;
      end
   end

   assign bus.busy_out                = busy_q;
   assign bus.dram_rd_req_out         = req_q;
   assign bus.dram_rd_addr_out        = addr_q;
   assign bus.ref_seq_block_out       = fifo_data;
   assign bus.ref_seq_block_valid_out = fifo_valid;

`ifdef DRAM_REF_READER_STATS_EN
   logic        capture;
   logic [31:0] stall_q;
   logic [31:0] wait_q;

   assign capture = (state_q == IDLE) && bus.ref_info_valid && (bus.ref_length_in != '0);

   always_ff @(posedge clk) begin
      if (rst || capture) begin
         stall_q <= '0;
         wait_q  <= '0;
      end else begin
         if (fifo_valid && !bus.ref_seq_block_rdy && (stall_q != '1)) stall_q <= stall_q + 1'b1;
         if (req_q && !bus.dram_rd_ack && (wait_q != '1)) wait_q <= wait_q + 1'b1;
      end
   end

   assign stall_cycles_out     = stall_q;
   assign dram_wait_cycles_out = wait_q;
`endif

endmodule

// File: tb/tb_dram_ref_reader.sv
// Scoreboard bench for dram_ref_reader: a DRAM model with programmable ack delay
// and 2-cycle return latency, plus an output monitor checking block order/data.
module tb_dram_ref_reader;

   localparam int REF_LENGTH = 256;
   localparam int DW         = 256;
   localparam int FIFO_DEPTH = 4;
   localparam int BLK_W      = 2 * REF_LENGTH;
   localparam int BEATS      = BLK_W / DW;

   typedef struct {
      logic [24:0] addr;
      int          due;
   } ret_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dram_ref_reader_if #(.REF_LENGTH(REF_LENGTH), .DRAM_WIDTH(DW)) bus ();

`ifdef DRAM_REF_READER_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] dram_wait_cycles;
`endif

   dram_ref_reader #(
      .REF_LENGTH (REF_LENGTH),
      .DRAM_WIDTH (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .bus                  (bus)
`ifdef DRAM_REF_READER_STATS_EN
      ,
      .stall_cycles_out     (stall_cycles),
      .dram_wait_cycles_out (dram_wait_cycles)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int ack_delay   = 0;
   int acc_cnt     = 0;
   int xfer_cnt    = 0;
   int last_xfer_cyc = 0;

   logic [BLK_W-1:0] sb [$];
   logic [24:0]      exp_req [$];
   ret_t             ret_q [$];

   task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(input logic [24:0] a);
      logic [DW-1:0] w;
      for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = {4'(j), 3'b101, a};
      return w;
   endfunction

   function automatic logic [BLK_W-1:0] block(input logic [24:0] base, input int k);
      logic [BLK_W-1:0] b;
      for (int i = 0; i < BEATS; i++) b[i*DW +: DW] = word(base + 25'(k * BEATS + i));
      return b;
   endfunction

   always @(negedge clk) cyc++;

   // DRAM controller model: ack after ack_delay waiting cycles, data 2 cycles after accept.
   logic        prev_ack = 1'b0;
   logic        prev_req = 1'b0;
   logic [24:0] prev_addr = '0;
   int          wait_cnt = 0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         ret_q.delete();
         exp_req.delete();
         bus.dram_rd_ack        = 1'b0;
         bus.dram_rd_data_valid = 1'b0;
         wait_cnt = 0;
         prev_ack = 1'b0;
         prev_req = 1'b0;
      end else begin
         if (prev_ack) begin
            ret_t r;
            acc_cnt++;
            if (exp_req.size() == 0) check("unexpected_req", BLK_W'(prev_addr), '1);
            else check("req_addr", BLK_W'(prev_addr), BLK_W'(exp_req.pop_front()));
            r.addr = prev_addr;
            r.due  = cyc + 1;
            ret_q.push_back(r);
         end else if (prev_req) begin
            check("req_hold", BLK_W'(bus.dram_rd_req_out), 1);
            check("addr_hold", BLK_W'(bus.dram_rd_addr_out), BLK_W'(prev_addr));
         end
         bus.dram_rd_data_valid = 1'b0;
         if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            ret_t r;
            r = ret_q.pop_front();
            bus.dram_rd_data_valid = 1'b1;
            bus.dram_rd_data       = word(r.addr);
         end
         if (bus.dram_rd_req_out) begin
            if (wait_cnt >= ack_delay) begin
               bus.dram_rd_ack = 1'b1;
               wait_cnt = 0;
            end else begin
               bus.dram_rd_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.dram_rd_ack = 1'b0;
            wait_cnt = 0;
         end
         prev_ack  = bus.dram_rd_ack;
         prev_req  = bus.dram_rd_req_out;
         prev_addr = bus.dram_rd_addr_out;
      end
   end

   // Output monitor: pops the scoreboard on every observed transfer.
   logic             prev_v = 1'b0;
   logic             prev_rdy = 1'b0;
   logic [BLK_W-1:0] prev_data = '0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         sb.delete();
         prev_v = 1'b0;
      end else begin
         if (prev_v && !prev_rdy) begin
            check("valid_hold", BLK_W'(bus.ref_seq_block_valid_out), 1);
            check("data_hold", bus.ref_seq_block_out, prev_data);
         end
         if (bus.ref_seq_block_valid_out && bus.ref_seq_block_rdy) begin
            if (sb.size() == 0) check("unexpected_block", bus.ref_seq_block_out, '1);
            else check("block_data", bus.ref_seq_block_out, sb.pop_front());
            xfer_cnt++;
            last_xfer_cyc = cyc;
         end
         prev_v    = bus.ref_seq_block_valid_out;
         prev_rdy  = bus.ref_seq_block_rdy;
         prev_data = bus.ref_seq_block_out;
      end
   end

   task automatic start(input logic [24:0] a, input logic [24:0] len);
      for (int i = 0; i < int'(len) * BEATS; i++) exp_req.push_back(a + 25'(i));
      for (int k = 0; k < int'(len); k++) sb.push_back(block(a, k));
      @(negedge clk);
      bus.ref_addr_in    = a;
      bus.ref_length_in  = len;
      bus.ref_info_valid = 1'b1;
      @(negedge clk);
      bus.ref_info_valid = 1'b0;
      #2;
      check("first_req", BLK_W'(bus.dram_rd_req_out), 1);
      check("busy_rise", BLK_W'(bus.busy_out), 1);
   endtask

   task automatic wait_done(input int n);
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #2;
         if (!bus.busy_out) break;
      end
      check("busy_fall", BLK_W'(bus.busy_out), 0);
      check("busy_fall_cycle", BLK_W'(cyc), BLK_W'(last_xfer_cyc + 1));
      check("block_count", BLK_W'(xfer_cnt), BLK_W'(n));
      check("sb_empty", BLK_W'(sb.size()), 0);
      check("req_q_empty", BLK_W'(exp_req.size()), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  BLK_W'(bus.busy_out), 0);
      check({tag, "_req"},   BLK_W'(bus.dram_rd_req_out), 0);
      check({tag, "_addr"},  BLK_W'(bus.dram_rd_addr_out), 0);
      check({tag, "_valid"}, BLK_W'(bus.ref_seq_block_valid_out), 0);
      check({tag, "_block"}, bus.ref_seq_block_out, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.ref_addr_in        = '0;
      bus.ref_length_in      = '0;
      bus.ref_info_valid     = 1'b0;
      bus.dram_rd_ack        = 1'b0;
      bus.dram_rd_data       = '0;
      bus.dram_rd_data_valid = 1'b0;
      bus.ref_seq_block_rdy  = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic three-block run.
      xfer_cnt = 0;
      start(25'h100, 3);
      wait_done(3);

      // Back-pressure: only FIFO_DEPTH blocks may be fetched while stalled.
      bus.ref_seq_block_rdy = 1'b0;
      xfer_cnt = 0;
      acc_cnt  = 0;
      start(25'h100, 6);
      repeat (40) @(negedge clk);
      #2;
      check("stall_req_count", BLK_W'(acc_cnt), BLK_W'(FIFO_DEPTH * BEATS));
      check("stall_req_low", BLK_W'(bus.dram_rd_req_out), 0);
      check("stall_valid", BLK_W'(bus.ref_seq_block_valid_out), 1);
      @(negedge clk);
      bus.ref_seq_block_rdy = 1'b1;
      wait_done(6);

      // Address wrap.
      xfer_cnt = 0;
      start(25'h1FFFFFF, 1);
      wait_done(1);

      // Slow acks: address must hold across every wait.
      ack_delay = 5;
      xfer_cnt  = 0;
      start(25'h3000, 2);
      wait_done(2);
`ifdef DRAM_REF_READER_STATS_EN
      check("dram_wait_cycles", BLK_W'(dram_wait_cycles), 5 * 2 * BEATS);
      check("stall_cycles", BLK_W'(stall_cycles), 0);
`endif
      ack_delay = 0;

      // Zero-length request ignored; request during FETCH ignored.
      @(negedge clk);
      bus.ref_addr_in    = 25'h500;
      bus.ref_length_in  = '0;
      bus.ref_info_valid = 1'b1;
      @(negedge clk);
      bus.ref_info_valid = 1'b0;
      #2;
      check("zero_len_busy", BLK_W'(bus.busy_out), 0);
      check("zero_len_req", BLK_W'(bus.dram_rd_req_out), 0);
      repeat (3) @(negedge clk);
      xfer_cnt = 0;
      start(25'h40, 2);
      @(negedge clk);
      bus.ref_addr_in    = 25'h999;
      bus.ref_length_in  = 25'd5;
      bus.ref_info_valid = 1'b1;
      repeat (2) @(negedge clk);
      bus.ref_info_valid = 1'b0;
      wait_done(2);

      // Reset after one beat of block 0 has returned.
      xfer_cnt = 0;
      start(25'h700, 2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      check_zero("mid_reset");
      check("mid_reset_xfers", BLK_W'(xfer_cnt), 0);
      start(25'h200, 1);
      wait_done(1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
